// File: rtl/cacheline_adapter.sv
// Cacheline adapter: serves one 256-bit line read or write from the cache DFP port
// as a 4-beat burst on the 64-bit bmem port, with a single-cycle dfp_resp.
module cacheline_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int KW    = $clog2(BEATS);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [KW-1:0]     K_LAST   = KW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BURST, DONE, REST} state_t;

    state_t            state;
    logic [KW-1:0]     k;
    logic [LINE_W-1:0] wdata_buf;
    logic [LINE_W-1:0] line_buf;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return a & ~OFF_MASK;
    endfunction

    function automatic logic [BEAT_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                    input logic [KW-1:0]     idx);
        return line[32'(idx) * BEAT_W +: BEAT_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_beat(input logic [LINE_W-1:0] line,
                                                    input logic [KW-1:0]     idx,
                                                    input logic [BEAT_W-1:0] beat);
        logic [LINE_W-1:0] r;
        r = line;
        r[32'(idx) * BEAT_W +: BEAT_W] = beat;
        return r;
    endfunction

    // bmem_addr doubles as the latched line address for the whole transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            dfp_resp   <= 1'b0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_addr  <= '0;
            bmem_wdata <= '0;
            dfp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    k <= '0;
                    if (dfp_write) begin
                        bmem_addr  <= line_align(dfp_addr);
                        wdata_buf  <= dfp_wdata;
                        bmem_wdata <= get_beat(dfp_wdata, '0);
                        bmem_write <= 1'b1;
                        state      <= WR_BURST;
                    end else if (dfp_read) begin
                        bmem_addr <= line_align(dfp_addr);
                        bmem_read <= 1'b1;
                        state     <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // beats tagged with another line address belong to someone else
                    if (bmem_rvalid && (bmem_raddr == bmem_addr)) begin
                        line_buf <= put_beat(line_buf, k, bmem_rdata);
                        k        <= k + KW'(1);
                        if (k == K_LAST) begin
                            dfp_rdata <= put_beat(line_buf, k, bmem_rdata);
                            dfp_resp  <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        k <= k + KW'(1);
                        if (k == K_LAST) begin
                            bmem_write <= 1'b0;
                            dfp_resp   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            bmem_wdata <= get_beat(wdata_buf, k + KW'(1));
                        end
                    end
                end
                DONE: begin
                    dfp_resp <= 1'b0;
                    k        <= '0;
                    state    <= REST;
                end
                REST: begin
                    // requester still sees its request high for a cycle after resp
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: a line-level model checked every cycle
// by a monitor, plus literal expectations for the headline transactions.
module tb_cacheline_adapter;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFE0;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    always #5 clk = ~clk;

    cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_rdata  (dfp_rdata),
        .dfp_resp   (dfp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Line-level model of the current transaction
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_line;
    logic [LINE_W-1:0] exp_held;
    bit                exp_is_write;
    bit                allow_resp;
    int                wcount, rd_count, resp_count;
    logic [BEAT_W-1:0] first_beat;
    logic [ADDR_W-1:0] last_rd_addr;
    logic [LINE_W-1:0] resp_rdata;
    bit                prev_read_acc, prev_wacc, prev_resp, wacc;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_read_acc = 0;
                prev_wacc     = 0;
                prev_resp     = 0;
            end else begin
                if (bmem_read) begin
                    chk("bmem_read_addr", LINE_W'(bmem_addr), LINE_W'(exp_addr));
                    last_rd_addr = bmem_addr;
                    if (prev_read_acc) chk("bmem_read_single", LINE_W'(bmem_read), LINE_W'(1'b0));
                    if (bmem_ready) rd_count++;
                end
                prev_read_acc = bmem_read && bmem_ready;
                if (bmem_write) begin
                    chk("bmem_write_addr", LINE_W'(bmem_addr), LINE_W'(exp_addr));
                    if (wcount < BEATS)
                        chk("bmem_wdata", LINE_W'(bmem_wdata), LINE_W'(exp_line[wcount*BEAT_W +: BEAT_W]));
                    else
                        chk("extra_write_beat", LINE_W'(bmem_write), LINE_W'(1'b0));
                    if (bmem_ready) begin
                        if (wcount == 0) first_beat = bmem_wdata;
                        wcount++;
                    end
                end
                wacc = bmem_write && bmem_ready;
                if (dfp_resp) begin
                    chk("resp_allowed", LINE_W'(dfp_resp), LINE_W'(allow_resp));
                    chk("resp_one_cycle", LINE_W'(prev_resp), LINE_W'(1'b0));
                    resp_count++;
                    if (exp_is_write) begin
                        chk("resp_after_last_beat", LINE_W'(prev_wacc), LINE_W'(1'b1));
                        chk("beats_at_resp", LINE_W'(wcount), LINE_W'(BEATS));
                    end else begin
                        exp_held   = exp_line;
                        resp_rdata = dfp_rdata;
                    end
                end
                chk("dfp_rdata", dfp_rdata, exp_held);
                prev_resp = dfp_resp;
                prev_wacc = wacc;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_dfp_resp"},   LINE_W'(dfp_resp),   '0);
        chk({tag, "_bmem_read"},  LINE_W'(bmem_read),  '0);
        chk({tag, "_bmem_write"}, LINE_W'(bmem_write), '0);
        chk({tag, "_bmem_addr"},  LINE_W'(bmem_addr),  '0);
        chk({tag, "_bmem_wdata"}, LINE_W'(bmem_wdata), '0);
        chk({tag, "_dfp_rdata"},  dfp_rdata,           '0);
    endtask

    task automatic start_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line, input bit allow);
        int n;
        exp_addr     = addr & LINE_MASK;
        exp_line     = line;
        exp_is_write = 0;
        allow_resp   = allow;
        rd_count     = 0;
        resp_count   = 0;
        dfp_addr     = addr;
        dfp_read     = 1'b1;
        n = 0;
        while (!bmem_read && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_cmd_seen", LINE_W'(bmem_read), LINE_W'(1'b1));
        dfp_addr = 32'hDEAD_BEEF;
    endtask

    task automatic send_beat(input logic [ADDR_W-1:0] a, input logic [BEAT_W-1:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        @(posedge clk); #1;
        bmem_rvalid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                           input int stray_after, input bit hold_extra);
        int n;
        start_read(addr, line, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        for (int b = 0; b < BEATS; b++) begin
            send_beat(exp_addr, line[b*BEAT_W +: BEAT_W]);
            if (b == stray_after) send_beat(32'h0000_0040, 64'hBAD0_BAD0_BAD0_BAD0);
        end
        n = 0;
        while (!dfp_resp && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("read_resp_seen", LINE_W'(dfp_resp), LINE_W'(1'b1));
        if (hold_extra) begin
            @(posedge clk); #1;
        end
        dfp_read = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("read_cmd_count", LINE_W'(rd_count), LINE_W'(1));
        chk("read_resp_count", LINE_W'(resp_count), LINE_W'(1));
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                            input logic [15:0] pat, input bit check_lat);
        int cyc, j;
        exp_addr     = addr & LINE_MASK;
        exp_line     = line;
        exp_is_write = 1;
        allow_resp   = 1;
        wcount       = 0;
        resp_count   = 0;
        dfp_addr     = addr;
        dfp_wdata    = line;
        dfp_write    = 1'b1;
        cyc = 0;
        j   = 0;
        while (!dfp_resp && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bmem_write) begin
                dfp_addr   = ~addr;
                dfp_wdata  = ~line;
                bmem_ready = (j < 16) ? pat[j] : 1'b1;
                j++;
            end else begin
                bmem_ready = 1'b1;
            end
        end
        chk("write_resp_seen", LINE_W'(dfp_resp), LINE_W'(1'b1));
        if (check_lat) chk("write_latency", LINE_W'(cyc), LINE_W'(5));
        dfp_write  = 1'b0;
        bmem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("write_beats", LINE_W'(wcount), LINE_W'(BEATS));
        chk("write_resp_count", LINE_W'(resp_count), LINE_W'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected summary before it");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        dfp_addr     = '0;
        dfp_read     = 1'b0;
        dfp_write    = 1'b0;
        dfp_wdata    = '0;
        bmem_ready   = 1'b1;
        bmem_raddr   = '0;
        bmem_rdata   = '0;
        bmem_rvalid  = 1'b0;
        exp_addr     = '0;
        exp_line     = '0;
        exp_held     = '0;
        exp_is_write = 0;
        allow_resp   = 0;
        wcount       = 0;
        rd_count     = 0;
        resp_count   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset");

        // 1: plain read, memory latency 5
        do_read(32'h0000_1234, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000}, -1, 0);
        chk("t1_bmem_addr", LINE_W'(last_rd_addr), LINE_W'(32'h0000_1220));
        chk("t1_rdata", resp_rdata, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                     64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000});

        // 2: write with memory always ready
        do_write(32'h8000_00E0, {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                 64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD}, 16'hFFFF, 1);
        chk("t2_first_beat", LINE_W'(first_beat), LINE_W'(64'hDDDD_DDDD_DDDD_DDDD));

        // 3: write with ready low in burst cycles 2-3
        do_write(32'h0000_5A47, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                 64'h5555_6666_7777_8888, 64'h9999_0000_1111_2222}, 16'hFFF9, 0);

        // 4: stray beat for another line between beats 1 and 2
        do_read(32'h0000_1220, {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
                                64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000}, 1, 0);

        // 5: reset after two beats of a read; late beats must be ignored
        start_read(32'h0000_1220, {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                                   64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send_beat(32'h0000_1220, 64'h7777_0000_0000_0000);
        send_beat(32'h0000_1220, 64'h7777_0000_0000_0001);
        rst      = 1'b1;
        dfp_read = 1'b0;
        exp_held = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("abort");
        send_beat(32'h0000_1220, 64'h7777_0000_0000_0002);
        send_beat(32'h0000_1220, 64'h7777_0000_0000_0003);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_resp_count", LINE_W'(resp_count), LINE_W'(0));
        chk("abort_rd_count", LINE_W'(rd_count), LINE_W'(1));

        // 6: fresh read after abort, request held through the guard cycle
        do_read(32'h0000_3318, {64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0002,
                                64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0000}, -1, 1);
        chk("t6_rdata", resp_rdata, {64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0002,
                                     64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0000});
        chk("t6_bmem_addr", LINE_W'(last_rd_addr), LINE_W'(32'h0000_3300));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
